// File: rtl/pt_buffer_stream.sv
// Plaintext buffer: NUM_BANKS parallel URAM banks behind a limb-addressed burst engine
// with whole-limb write/read bursts, read-latency tracking and a per-limb loaded scoreboard.

module uram_bank #(
   parameter int DATA_WIDTH = 216,
   parameter int ADDR_WIDTH = 13,
   parameter int RD_LAT     = 2
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata
);
   logic [DATA_WIDTH-1:0] mem  [1<<ADDR_WIDTH];
   logic [DATA_WIDTH-1:0] pipe [RD_LAT];

   // Contents and read pipeline are deliberately unreset; validity is tracked by the caller.
   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      pipe[0] <= mem[addr];
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
   end

   assign rdata = pipe[RD_LAT-1];
endmodule

// state | meaning
// IDLE  | waiting for wr_start / rd_start / clear
// WRITE | accepting one limb of beats on wr_valid, gaps allowed
// READ  | issuing one address per cycle, then draining the latency pipeline
module pt_buffer_stream #(
   parameter int NUM_BANKS      = 128,
   parameter int DATA_WIDTH     = 216,
   parameter int NUM_LIMBS      = 32,
   parameter int WORDS_PER_LIMB = 256,
   parameter int ADDR_WIDTH     = 13,
   parameter int RD_LAT         = 2
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            wr_start,
   input  logic [$clog2(NUM_LIMBS)-1:0]    wr_limb,
   input  logic                            wr_valid,
   output logic                            wr_ready,
   input  logic [NUM_BANKS*DATA_WIDTH-1:0] wr_data,
   input  logic                            rd_start,
   input  logic [$clog2(NUM_LIMBS)-1:0]    rd_limb,
   output logic                            rd_valid,
   output logic [NUM_BANKS*DATA_WIDTH-1:0] rd_data,
   output logic                            rd_last,
   output logic                            busy,
   output logic                            done,
   output logic                            err,
   input  logic                            clear,
   output logic [NUM_LIMBS-1:0]            limb_loaded
);
   localparam int LW    = $clog2(NUM_LIMBS);
   localparam int BW    = $clog2(WORDS_PER_LIMB);
   localparam int BUS_W = NUM_BANKS * DATA_WIDTH;
   localparam logic [BW-1:0] LAST_BEAT = BW'(WORDS_PER_LIMB - 1);

   typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

   state_t              state, state_nxt;
   logic [BW-1:0]       beat;
   logic [LW-1:0]       limb;
   logic                drain;
   logic [RD_LAT-1:0]   vld_pipe, last_pipe;
   logic                done_wr, err_q;
   logic [BUS_W-1:0]    bank_rd, rd_hold;
   logic                idle, start_wr, start_rd, reject_rd;
   logic                acc_wr, last_wr, issue, last_issue;
   logic [ADDR_WIDTH-1:0] addr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      idle       = (state == IDLE);
      start_wr   = idle && wr_start;
      start_rd   = idle && !wr_start && rd_start && limb_loaded[rd_limb];
      reject_rd  = idle && !wr_start && rd_start && !limb_loaded[rd_limb];
      acc_wr     = (state == WRITE) && wr_valid;
      last_wr    = acc_wr && (beat == LAST_BEAT);
      issue      = (state == READ) && !drain;
      last_issue = issue && (beat == LAST_BEAT);
      state_nxt  = state;
      unique case (state)
         IDLE:    if (start_wr) state_nxt = WRITE;
                  else if (start_rd) state_nxt = READ;
         WRITE:   if (last_wr) state_nxt = IDLE;
         READ:    if (rd_last) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat        <= '0;
         limb        <= '0;
         drain       <= 1'b0;
         done_wr     <= 1'b0;
         err_q       <= 1'b0;
         limb_loaded <= '0;
         vld_pipe    <= '0;
         last_pipe   <= '0;
         rd_hold     <= '0;
      end else begin
         done_wr <= last_wr;
         err_q   <= reject_rd;
         if (start_wr)      limb <= wr_limb;
         else if (start_rd) limb <= rd_limb;
         if (last_wr || last_issue)  beat <= '0;
         else if (acc_wr || issue)   beat <= beat + BW'(1);
         // drain covers the RD_LAT cycles between the final issue and rd_last
         if (last_issue)   drain <= 1'b1;
         else if (rd_last) drain <= 1'b0;
         if (idle && clear) limb_loaded <= '0;
         else if (last_wr)  limb_loaded <= limb_loaded | (NUM_LIMBS'(1) << limb);
         vld_pipe[0]  <= issue;
         last_pipe[0] <= last_issue;
         for (int i = 1; i < RD_LAT; i++) begin
            vld_pipe[i]  <= vld_pipe[i-1];
            last_pipe[i] <= last_pipe[i-1];
         end
         if (rd_valid) rd_hold <= bank_rd;
      end
   end

   assign addr = ADDR_WIDTH'({limb, beat});

   for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
      uram_bank #(
         .DATA_WIDTH (DATA_WIDTH),
         .ADDR_WIDTH (ADDR_WIDTH),
         .RD_LAT     (RD_LAT)
      ) u_bank (
         .clk   (clk),
         .we    (acc_wr),
         .addr  (addr),
         .wdata (wr_data[g*DATA_WIDTH +: DATA_WIDTH]),
         .rdata (bank_rd[g*DATA_WIDTH +: DATA_WIDTH])
      );
   end

   assign wr_ready = (state == WRITE);
   assign busy     = !idle;
   assign rd_valid = vld_pipe[RD_LAT-1];
   assign rd_last  = last_pipe[RD_LAT-1];
   assign done     = done_wr | rd_last;
   assign err      = err_q;
   assign rd_data  = rd_valid ? bank_rd : rd_hold;
endmodule

// File: tb/tb_pt_buffer_stream.sv
// Directed bench for pt_buffer_stream: 4 banks, 8 words per limb, read latency 2.
`timescale 1ns/1ps
module tb_pt_buffer_stream;
   localparam int NB = 4, DW = 16, NL = 32, WPL = 8, AW = 8, RL = 2;
   localparam int LW = $clog2(NL);
   localparam int BUS_W = NB * DW;

   logic clk = 0, rst_n = 0;
   logic wr_start = 0, wr_valid = 0, rd_start = 0, clear = 0;
   logic [LW-1:0] wr_limb = '0, rd_limb = '0;
   logic [BUS_W-1:0] wr_data = '0, rd_data;
   logic wr_ready, rd_valid, rd_last, busy, done, err;
   logic [NL-1:0] limb_loaded;

   int vectors = 0, miscompares = 0;

   pt_buffer_stream #(
      .NUM_BANKS(NB), .DATA_WIDTH(DW), .NUM_LIMBS(NL),
      .WORDS_PER_LIMB(WPL), .ADDR_WIDTH(AW), .RD_LAT(RL)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .wr_start(wr_start), .wr_limb(wr_limb), .wr_valid(wr_valid),
      .wr_ready(wr_ready), .wr_data(wr_data),
      .rd_start(rd_start), .rd_limb(rd_limb), .rd_valid(rd_valid),
      .rd_data(rd_data), .rd_last(rd_last),
      .busy(busy), .done(done), .err(err),
      .clear(clear), .limb_loaded(limb_loaded)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk); #1;
   endtask

   // Limb 3 uses the plain 16*bank+beat pattern; other limbs get a limb offset.
   function automatic logic [BUS_W-1:0] pat(input int l, input int b);
      logic [BUS_W-1:0] v;
      int base;
      base = (l == 3) ? 0 : l * 256;
      for (int i = 0; i < NB; i++) v[i*DW +: DW] = DW'(base + 16*i + b);
      return v;
   endfunction

   task automatic do_write(input int l, input bit gaps, input bit rd_with_start, input bit rd_mid,
                           output int rdy_cycles, output int done_cnt, output int err_cnt,
                           output int rdv_cnt);
      int b, cyc;
      bit tog, seen;
      b = 0; cyc = 0; tog = 0; seen = 0;
      rdy_cycles = 0; done_cnt = 0; err_cnt = 0; rdv_cnt = 0;
      wr_start = 1; wr_limb = LW'(l);
      rd_start = rd_with_start; rd_limb = LW'(5);
      step();
      wr_start = 0; rd_start = 0;
      while (cyc < 64) begin
         if (done) done_cnt++;
         if (err) err_cnt++;
         if (rd_valid) rdv_cnt++;
         if (wr_ready) begin
            seen = 1; rdy_cycles++;
            wr_valid = gaps ? tog : 1'b1;
            tog = !tog;
            wr_data = pat(l, b);
            if (rd_mid && rdy_cycles == 5) begin rd_start = 1; rd_limb = LW'(3); end
            else rd_start = 0;
         end else if (seen) break;
         else wr_valid = 0;
         step(); cyc++;
         if (wr_valid) b++;
      end
      wr_valid = 0; rd_start = 0;
      if (cyc >= 64) begin
         miscompares++; vectors++;
         $display("FAIL write_timeout limb=%0d got beats=%0d exp %0d", l, b, WPL);
      end
      repeat (2) begin
         step();
         if (done) done_cnt++;
         if (err) err_cnt++;
         if (rd_valid) rdv_cnt++;
      end
   endtask

   task automatic do_read(input int l, input int abort_at);
      bit exp_v;
      rd_start = 1; rd_limb = LW'(l);
      step();
      rd_start = 0;
      for (int k = 0; k < 12; k++) begin
         if (k == abort_at) begin
            rst_n = 0; #1;
            vectors++;
            if (rd_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || limb_loaded !== '0) begin
               miscompares++;
               $display("FAIL reset_mid_read got valid=%b done=%b busy=%b loaded=%h exp 0 0 0 0",
                        rd_valid, done, busy, limb_loaded);
            end
            step(); rst_n = 1;
            return;
         end
         exp_v = (k >= 2 && k <= 9);
         vectors++;
         if (rd_valid !== exp_v) begin
            miscompares++; $display("FAIL rd_valid k=%0d got %b exp %b", k, rd_valid, exp_v);
         end
         vectors++;
         if (rd_last !== (k == 9)) begin
            miscompares++; $display("FAIL rd_last k=%0d got %b exp %b", k, rd_last, k == 9);
         end
         vectors++;
         if (done !== (k == 9)) begin
            miscompares++; $display("FAIL rd_done k=%0d got %b exp %b", k, done, k == 9);
         end
         vectors++;
         if (busy !== (k <= 9)) begin
            miscompares++; $display("FAIL rd_busy k=%0d got %b exp %b", k, busy, k <= 9);
         end
         if (exp_v) begin
            vectors++;
            if (rd_data !== pat(l, k-2)) begin
               miscompares++;
               $display("FAIL rd_data limb=%0d beat=%0d got %h exp %h", l, k-2, rd_data, pat(l, k-2));
            end
         end
         if (k == 10) begin
            vectors++;
            if (rd_data !== pat(l, 7)) begin
               miscompares++; $display("FAIL rd_hold got %h exp %h", rd_data, pat(l, 7));
            end
         end
         step();
      end
   endtask

   task automatic check_write(input string nm, input int rdy, input int dn, input int er, input int rv,
                              input int exp_rdy, input logic [NL-1:0] exp_loaded);
      vectors++;
      if (rdy !== exp_rdy || dn !== 1 || er !== 0 || rv !== 0) begin
         miscompares++;
         $display("FAIL %s got ready=%0d done=%0d err=%0d rdv=%0d exp %0d 1 0 0", nm, rdy, dn, er, rv, exp_rdy);
      end
      vectors++;
      if (limb_loaded !== exp_loaded || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL %s_loaded got %h busy=%b exp %h busy=0", nm, limb_loaded, busy, exp_loaded);
      end
   endtask

   task automatic test_reset();
      repeat (3) step();
      vectors++;
      if (wr_ready !== 0 || rd_valid !== 0 || rd_last !== 0 || busy !== 0 || done !== 0 || err !== 0) begin
         miscompares++;
         $display("FAIL reset_ctrl got rdy=%b v=%b l=%b busy=%b done=%b err=%b exp all 0",
                  wr_ready, rd_valid, rd_last, busy, done, err);
      end
      vectors++;
      if (rd_data !== '0 || limb_loaded !== '0) begin
         miscompares++; $display("FAIL reset_data got %h %h exp 0 0", rd_data, limb_loaded);
      end
      rst_n = 1;
      step();
      vectors++;
      if (busy !== 0 || wr_ready !== 0) begin
         miscompares++; $display("FAIL post_reset got busy=%b rdy=%b exp 0 0", busy, wr_ready);
      end
   endtask

   task automatic test_write_basic();
      int r, d, e, v;
      do_write(3, 0, 0, 0, r, d, e, v);
      check_write("write_basic", r, d, e, v, 8, 32'h8);
   endtask

   task automatic test_read_basic();
      do_read(3, -1);
   endtask

   task automatic expect_err(input string nm, input int l);
      int rv;
      rv = 0;
      rd_start = 1; rd_limb = LW'(l);
      step();
      rd_start = 0;
      vectors++;
      if (err !== 1'b1 || busy !== 1'b0) begin
         miscompares++; $display("FAIL %s got err=%b busy=%b exp 1 0", nm, err, busy);
      end
      repeat (4) begin
         step();
         if (rd_valid || err || busy) rv++;
      end
      vectors++;
      if (rv !== 0) begin
         miscompares++; $display("FAIL %s_after got %0d active cycles exp 0", nm, rv);
      end
   endtask

   task automatic test_err();
      expect_err("err_unloaded", 5);
   endtask

   task automatic test_wr_rd_same_cycle();
      int r, d, e, v;
      do_write(0, 0, 1, 0, r, d, e, v);
      check_write("write_with_rd", r, d, e, v, 8, 32'h9);
   endtask

   task automatic test_gapped_write();
      int r, d, e, v;
      do_write(1, 1, 0, 1, r, d, e, v);
      check_write("write_gapped", r, d, e, v, 16, 32'hB);
      do_read(1, -1);
   endtask

   task automatic test_clear();
      clear = 1;
      step();
      clear = 0;
      vectors++;
      if (limb_loaded !== '0) begin
         miscompares++; $display("FAIL clear got %h exp 0", limb_loaded);
      end
      expect_err("err_after_clear", 3);
   endtask

   task automatic test_reset_mid_read();
      int r, d, e, v;
      do_write(3, 0, 0, 0, r, d, e, v);
      check_write("rewrite3", r, d, e, v, 8, 32'h8);
      do_read(3, 6);
      step();
      vectors++;
      if (busy !== 0 || rd_valid !== 0 || done !== 0 || limb_loaded !== '0) begin
         miscompares++;
         $display("FAIL post_abort got busy=%b v=%b done=%b loaded=%h exp 0 0 0 0",
                  busy, rd_valid, done, limb_loaded);
      end
      do_write(2, 0, 0, 0, r, d, e, v);
      check_write("write_after_reset", r, d, e, v, 8, 32'h4);
      do_read(2, -1);
   endtask

   initial begin
      test_reset();
      test_write_basic();
      test_read_basic();
      test_err();
      test_wr_rd_same_cycle();
      test_gapped_write();
      test_clear();
      test_reset_mid_read();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got running exp finished");
      $fatal(1, "timeout");
   end
endmodule
